// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//
// Execute-stage multiply/divide unit. Owns the architectural HI/LO registers
// and runs MULT/MULTU/DIV/DIVU/MADD as fixed-latency multi-cycle operations.
// MTHI/MTLO writes complete at the accepting edge with no busy time.
//
// Ports:
//   clk       in   1   clock, all state changes on the rising edge
//   reset     in   1   synchronous active-high reset (aborts any operation)
//   start     in   1   launch the operation selected by mulOp
//   mulOp     in   2   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   mulWe     in   1   HI/LO write request, qualified by HiLo
//   HiLo      in   2   00 MTLO, 01 MTHI, 10 MADD, 11 no-op
//   A         in  32   forwarded rs operand
//   B         in  32   forwarded rt operand
//   hi        out 32   HI register
//   lo        out 32   LO register
//   busy      out  1   operation in progress (registered; equals state RUN)
//   stallReq  out  1   combinational stall request for the hazard unit
//
// Handshake: requests (start, or mulWe with HiLo=10) are accepted only while
// busy is low; in that case the edge that samples them is the launch edge.
// While busy is high every request is ignored. busy rises the cycle after
// launch and falls the cycle after the committing edge.
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mulOp,
    input  logic        mulWe,
    input  logic [1:0]  HiLo,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stallReq
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;

    localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

    logic        state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Result datapath, evaluated on the latched operands.
    logic [63:0] prod_u, prod_s, madd_sum;
    logic [31:0] quo_u, rem_u;
    logic [31:0] abs_a, abs_b, quo_mag, rem_mag, quo_s, rem_s;
    logic        div_zero;

    always_comb begin
        prod_u   = {32'h0, a_q} * {32'h0, b_q};
        // Sign-extend to 64 bits; the low 64 bits of the product are the
        // exact signed product.
        prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        madd_sum = {hi_q, lo_q} + prod_s;
        div_zero = (b_q == 32'h0);
        quo_u    = div_zero ? 32'h0 : (a_q / b_q);
        rem_u    = div_zero ? 32'h0 : (a_q % b_q);
        // Signed divide on magnitudes: quotient negated when signs differ,
        // remainder follows the dividend. 0x80000000 has magnitude
        // 0x80000000 as unsigned, so 0x80000000 / -1 yields 0x80000000.
        abs_a    = a_q[31] ? (32'h0 - a_q) : a_q;
        abs_b    = b_q[31] ? (32'h0 - b_q) : b_q;
        quo_mag  = div_zero ? 32'h0 : (abs_a / abs_b);
        rem_mag  = div_zero ? 32'h0 : (abs_a % abs_b);
        quo_s    = (a_q[31] ^ b_q[31]) ? (32'h0 - quo_mag) : quo_mag;
        rem_s    = a_q[31] ? (32'h0 - rem_mag) : rem_mag;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    op_d    = {1'b0, mulOp};
                    a_d     = A;
                    b_d     = B;
                    count_d = mulOp[1] ? DIV_N : MUL_N;
                end else if (mulWe) begin
                    case (HiLo)
                        2'b00: lo_d = A;
                        2'b01: hi_d = A;
                        2'b10: begin
                            state_d = ST_RUN;
                            op_d    = OP_MADD;
                            a_d     = A;
                            b_d     = B;
                            count_d = MUL_N;
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                if (count_q == 4'd1) begin
                    state_d = ST_IDLE;
                    count_d = 4'd0;
                    case (op_q)
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MADD:  {hi_d, lo_d} = madd_sum;
                        OP_DIVU: if (!div_zero) begin
                            hi_d = rem_u;
                            lo_d = quo_u;
                        end
                        OP_DIV: if (!div_zero) begin
                            hi_d = rem_s;
                            lo_d = quo_s;
                        end
                        default: ;
                    endcase
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= 4'd0;
            op_q    <= OP_MULTU;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            hi_q    <= 32'h0;
            lo_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q == ST_RUN);
    assign stallReq = start | busy | (mulWe & (HiLo == 2'b10));

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  mulOp;
  logic        mulWe;
  logic [1:0]  HiLo;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stallReq;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q[$];
  logic [63:0] m_hilo;  // bench model of {HI,LO}

  mul_div_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .mulOp(mulOp),
    .mulWe(mulWe), .HiLo(HiLo), .A(A), .B(B),
    .hi(hi), .lo(lo), .busy(busy), .stallReq(stallReq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model: 64-bit arithmetic on sign/zero extended operands.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb, q, r;
    logic [63:0] qv, rv, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = cur;
    case (op)
      3'd0: res = {32'h0, a} * {32'h0, b};
      3'd1: res = 64'(sa * sb);
      3'd2: if (b != 0) res = {a % b, a / b};
      3'd3: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        qv = 64'(q);
        rv = 64'(r);
        res = {rv[31:0], qv[31:0]};
      end
      3'd4: res = cur + 64'(sa * sb);
      default: res = cur;
    endcase
    return res;
  endfunction

  // driver: op 0..3 via start/mulOp, op 4 = MADD via mulWe/HiLo=10
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    A = a;
    B = b;
    if (op == 3'd4) begin
      mulWe = 1'b1;
      HiLo  = 2'b10;
    end else begin
      start = 1'b1;
      mulOp = op[1:0];
    end
    exp_q.push_back(model(op, a, b, m_hilo));
    #1;
    check({tag, " stallReq@launch"}, 64'(stallReq), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    mulWe = 1'b0;
    HiLo  = 2'b11;
  endtask

  // count remaining busy cycles, then pop and compare the committed result
  task automatic wait_done(input int n_exp, input int already, input string tag);
    int n;
    logic [63:0] e;
    n = already;
    while (busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check({tag, " busy_cycles"}, 64'(n), 64'(n_exp));
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty at commit", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, " hilo"}, {hi, lo}, e);
      m_hilo = e;
    end
  endtask

  task automatic write_hilo(input logic [1:0] sel, input logic [31:0] a);
    mulWe = 1'b1;
    HiLo  = sel;
    A     = a;
    @(posedge clk); #1;
    mulWe = 1'b0;
    HiLo  = 2'b11;
    if (sel == 2'b00) m_hilo[31:0] = a;
    if (sel == 2'b01) m_hilo[63:32] = a;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    reset = 1'b1; start = 1'b0; mulOp = 2'b00; mulWe = 1'b0; HiLo = 2'b11;
    A = 32'h0; B = 32'h0; m_hilo = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset hilo", {hi, lo}, 64'h0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset stallReq", 64'(stallReq), 64'd0);

    // MULT -3 * 5
    launch(3'd1, 32'hFFFF_FFFD, 32'd5, "mult");
    wait_done(MUL_N, 0, "mult");
    check("mult const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    // DIVU 7/2, DIV -7/2, DIV overflow corner
    launch(3'd2, 32'd7, 32'd2, "divu");
    wait_done(DIV_N, 0, "divu");
    check("divu const", {hi, lo}, {32'd1, 32'd3});
    launch(3'd3, 32'hFFFF_FFF9, 32'd2, "div");
    wait_done(DIV_N, 0, "div");
    check("div const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    launch(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    wait_done(DIV_N, 0, "div_ovf");
    check("div_ovf const", {hi, lo}, 64'h0000_0000_8000_0000);

    // MTHI then MTLO back to back
    mulWe = 1'b1; HiLo = 2'b01; A = 32'h1234_5678;
    #1;
    check("mthi stallReq", 64'(stallReq), 64'd0);
    @(posedge clk); #1;
    check("mthi hi", 64'(hi), 64'h1234_5678);
    check("mthi busy", 64'(busy), 64'd0);
    HiLo = 2'b00; A = 32'h1;
    @(posedge clk); #1;
    mulWe = 1'b0; HiLo = 2'b11;
    check("mtlo hilo", {hi, lo}, {32'h1234_5678, 32'h1});
    check("mtlo busy", 64'(busy), 64'd0);
    m_hilo = {32'h1234_5678, 32'h1};

    // MADD accumulate with carry into HI
    write_hilo(2'b01, 32'h0);
    write_hilo(2'b00, 32'd10);
    launch(3'd4, 32'hFFFF_FFFE, 32'd3, "madd1");
    wait_done(MUL_N, 0, "madd1");
    check("madd1 const", {hi, lo}, 64'h0000_0000_0000_0004);
    launch(3'd4, 32'h7FFF_FFFF, 32'd2, "madd2");
    wait_done(MUL_N, 0, "madd2");
    check("madd2 const", {hi, lo}, 64'h0000_0001_0000_0002);

    // HiLo=11 is a no-op
    mulWe = 1'b1; HiLo = 2'b11; A = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mulWe = 1'b0;
    check("hilo11 hilo", {hi, lo}, m_hilo);
    check("hilo11 busy", 64'(busy), 64'd0);

    // divide by zero; requests during busy are ignored
    write_hilo(2'b01, 32'hAA);
    write_hilo(2'b00, 32'hBB);
    launch(3'd3, 32'd100, 32'd0, "divz");
    mulWe = 1'b1; HiLo = 2'b00; A = 32'hDEAD; start = 1'b1; mulOp = 2'b00;
    #1;
    check("divz stallReq busy", 64'(stallReq), 64'd1);
    @(posedge clk); #1;
    check("divz hold", {hi, lo}, {32'hAA, 32'hBB});
    mulWe = 1'b0; HiLo = 2'b11; start = 1'b0;
    wait_done(DIV_N, 1, "divz");
    check("divz const", {hi, lo}, {32'hAA, 32'hBB});

    // start and mulWe together: start wins, MTLO dropped
    mulWe = 1'b1; HiLo = 2'b00;
    launch(3'd0, 32'd3, 32'd4, "prio");
    check("prio lo held", 64'(lo), 64'hBB);
    wait_done(MUL_N, 0, "prio");
    check("prio const", {hi, lo}, 64'd12);

    // reset mid-operation aborts it
    launch(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "abort");
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort busy before reset", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    m_hilo = 64'h0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort hilo", {hi, lo}, 64'h0);
    launch(3'd1, 32'd6, 32'd7, "after_abort");
    wait_done(MUL_N, 0, "after_abort");

    // random MULTU/MULT/DIVU/DIV/MADD
    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom_range(0, 4));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      launch(rop, ra, rb, "rand");
      wait_done((rop == 3'd2 || rop == 3'd3) ? DIV_N : MUL_N, 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
